// File: rtl/fp_add_sequencer_pkg.sv
// Shared types for the floating-point adder sequencer: operand type,
// sequencer states and the captured output bundle.
package fp_add_sequencer_pkg;

    typedef logic [31:0] float;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } seq_state_t;

    typedef struct packed {
        float result;
        logic zero;
        logic inf;
        logic nan;
        logic timed_out;
    } out_bundle_t;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/fp_add_watchdog.sv
// Ready rising-edge detector and per-operation timeout counter used while
// the sequencer waits on the adder.
module fp_add_watchdog
    import fp_add_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic active,
    input  logic adder_ready,
    output logic capture,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q, count_d;
    logic          ready_prev_q, ready_prev_d;

    // Only a fresh rising edge counts, so a Ready level left over from the
    // previous operation cannot complete the current one.
    always_comb begin
        capture      = active && adder_ready && !ready_prev_q;
        expire       = active && !capture && (count_q == LAST);
        ready_prev_d = adder_ready;
        count_d      = count_q;
        if (clear) begin
            count_d = '0;
        end else if (active && !capture && !expire) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q      <= '0;
            ready_prev_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            ready_prev_q <= ready_prev_d;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Issue/collect stage in front of FloatingPointAdder: takes operand pairs on
// a valid/ready stream, pulses Go, and returns the captured result bundle.
module fp_add_sequencer
    import fp_add_sequencer_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNTW    = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  float            InA,
    input  float            InB,
    input  logic            InValid,
    output logic            InReady,
    output float            AddendA,
    output float            AddendB,
    output logic            Go,
    input  float            AdderResult,
    input  logic            AdderReady,
    input  logic            AdderZero,
    input  logic            AdderInf,
    input  logic            AdderNan,
    output float            OutResult,
    output logic            OutZero,
    output logic            OutInf,
    output logic            OutNan,
    output logic            OutTimedOut,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [CNTW-1:0] OpCount
);

    seq_state_t      state_q, state_d;
    float            addend_a_q, addend_a_d;
    float            addend_b_q, addend_b_d;
    out_bundle_t     out_q, out_d;
    logic [CNTW-1:0] op_count_q, op_count_d;
    logic            accept;
    logic            capture;
    logic            expire;

    fp_add_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear      (state_q == ISSUE),
        .active     (state_q == WAIT),
        .adder_ready(AdderReady),
        .capture    (capture),
        .expire     (expire)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pair accepted while the previous bundle drains goes straight to ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (capture || expire) state_d = HOLD;
            HOLD:    if (OutReady) state_d = accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        InReady  = (state_q == IDLE) || ((state_q == HOLD) && OutReady);
        Go       = (state_q == ISSUE);
        OutValid = (state_q == HOLD);
        accept   = InValid && InReady;
    end

    always_comb begin
        addend_a_d = accept ? InA : addend_a_q;
        addend_b_d = accept ? InB : addend_b_q;
        out_d      = out_q;
        if (capture) begin
            out_d = '{result: AdderResult, zero: AdderZero, inf: AdderInf,
                      nan: AdderNan, timed_out: 1'b0};
        end else if (expire) begin
            out_d = '{result: '0, zero: 1'b0, inf: 1'b0, nan: 1'b0, timed_out: 1'b1};
        end
        op_count_d = op_count_q;
        if (OutValid && OutReady) begin
            op_count_d = op_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            addend_a_q <= '0;
            addend_b_q <= '0;
            out_q      <= '0;
            op_count_q <= '0;
        end else begin
            addend_a_q <= addend_a_d;
            addend_b_q <= addend_b_d;
            out_q      <= out_d;
            op_count_q <= op_count_d;
        end
    end

    assign AddendA     = addend_a_q;
    assign AddendB     = addend_b_q;
    assign OutResult   = out_q.result;
    assign OutZero     = out_q.zero;
    assign OutInf      = out_q.inf;
    assign OutNan      = out_q.nan;
    assign OutTimedOut = out_q.timed_out;
    assign OpCount     = op_count_q;

    assert property (@(posedge Clock) disable iff (Reset) Go |=> !Go);
    assert property (@(posedge Clock) disable iff (Reset)
                     (OutValid && !OutReady) |=> $stable(out_q));

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer with a behavioural adder stub that
// returns hand-computed sums after a programmable delay.
module tb_fp_add_sequencer;
    import fp_add_sequencer_pkg::*;

    localparam int TIMEOUT = 8;
    localparam int CNTW    = 16;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_STUCK  = 2;

    logic            Clock;
    logic            Reset;
    float            InA, InB;
    logic            InValid, InReady;
    float            AddendA, AddendB;
    logic            Go;
    float            AdderResult;
    logic            AdderReady, AdderZero, AdderInf, AdderNan;
    float            OutResult;
    logic            OutZero, OutInf, OutNan, OutTimedOut, OutValid, OutReady;
    logic [CNTW-1:0] OpCount;

    typedef struct {
        float a;
        float b;
        float res;
        logic z;
        logic i;
        logic n;
        int   lat;
        int   mode;
    } issue_t;

    typedef struct {
        logic [35:0]     bundle;
        logic [CNTW-1:0] cnt;
    } exp_t;

    issue_t issueQ[$];
    exp_t   sbQ[$];
    int     tests = 0;
    int     fails = 0;
    int     pushCount = 0;
    int     cycles;

    fp_add_sequencer #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .InA        (InA),
        .InB        (InB),
        .InValid    (InValid),
        .InReady    (InReady),
        .AddendA    (AddendA),
        .AddendB    (AddendB),
        .Go         (Go),
        .AdderResult(AdderResult),
        .AdderReady (AdderReady),
        .AdderZero  (AdderZero),
        .AdderInf   (AdderInf),
        .AdderNan   (AdderNan),
        .OutResult  (OutResult),
        .OutZero    (OutZero),
        .OutInf     (OutInf),
        .OutNan     (OutNan),
        .OutTimedOut(OutTimedOut),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OpCount    (OpCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic boundFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got timeout expected event", name);
    endtask

    // Queues the pair for the stub and scoreboard, then holds it until accepted.
    task automatic applyStimulus(input float a, input float b, input float res,
                                 input logic z, input logic i, input logic n,
                                 input int lat, input int mode, input bit track);
        issue_t it;
        exp_t   e;
        int     waitCnt;
        it = '{a, b, res, z, i, n, lat, mode};
        issueQ.push_back(it);
        if (track) begin
            e.bundle = (mode == MODE_NEVER) ? {32'h0, 3'b000, 1'b1} : {res, z, i, n, 1'b0};
            e.cnt    = CNTW'(pushCount);
            pushCount++;
            sbQ.push_back(e);
        end
        InA     = a;
        InB     = b;
        InValid = 1'b1;
        waitCnt = 0;
        forever begin
            @(negedge Clock);
            #1;
            if (InReady) break;
            waitCnt++;
            if (waitCnt > 200) begin
                boundFail("accept_wait");
                break;
            end
        end
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        InA     = 32'hDEADBEEF;
        InB     = 32'h12345678;
    endtask

    task automatic measureLatency(input string name, input int expected);
        int n;
        n = 0;
        forever begin
            @(negedge Clock);
            #1;
            n++;
            if (OutValid) break;
            if (n > 100) break;
        end
        checkOutput(name, n, expected);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 500) begin
            @(negedge Clock);
            #1;
            n++;
        end
        if (sbQ.size() != 0) boundFail("drain_wait");
        @(posedge Clock);
        #1;
    endtask

    // Adder stub: responds to each Go with the queued sum after its delay.
    initial begin
        issue_t it;
        AdderReady  = 1'b0;
        AdderResult = '0;
        AdderZero   = 1'b0;
        AdderInf    = 1'b0;
        AdderNan    = 1'b0;
        forever begin
            @(negedge Clock);
            if (Go === 1'b1 && !Reset) begin
                if (issueQ.size() == 0) begin
                    boundFail("go_unexpected");
                end else begin
                    it = issueQ.pop_front();
                    checkOutput("addend_a", AddendA, it.a);
                    checkOutput("addend_b", AddendB, it.b);
                    if (it.mode == MODE_STUCK) begin
                        repeat (3) @(negedge Clock);
                        AdderReady = 1'b0;
                        repeat (2) @(negedge Clock);
                    end else begin
                        AdderReady = 1'b0;
                        if (it.mode == MODE_NORMAL) repeat (it.lat) @(negedge Clock);
                    end
                    if (it.mode != MODE_NEVER) begin
                        AdderResult = it.res;
                        AdderZero   = it.z;
                        AdderInf    = it.i;
                        AdderNan    = it.n;
                        AdderReady  = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake and watches
    // Go pulses, bundle stability and the HOLD-to-ISSUE path.
    initial begin
        logic        goPrev;
        logic        held;
        logic        expectGo;
        logic [35:0] heldVals;
        logic [35:0] bundle;
        exp_t        e;
        goPrev   = 1'b0;
        held     = 1'b0;
        expectGo = 1'b0;
        heldVals = '0;
        forever begin
            @(negedge Clock);
            #1;
            if (Reset) begin
                goPrev   = 1'b0;
                held     = 1'b0;
                expectGo = 1'b0;
                continue;
            end
            bundle = {OutResult, OutZero, OutInf, OutNan, OutTimedOut};
            if (expectGo) checkOutput("hold_to_issue", Go, 1'b1);
            expectGo = 1'b0;
            if (Go) checkOutput("go_single_pulse", goPrev, 1'b0);
            goPrev = Go;
            if (OutValid && held) checkOutput("out_stable", bundle, heldVals);
            if (OutValid && !OutReady) begin
                checkOutput("inready_blocked", InReady, 1'b0);
                held     = 1'b1;
                heldVals = bundle;
            end else begin
                held = 1'b0;
            end
            if (OutValid && OutReady) begin
                if (sbQ.size() == 0) begin
                    boundFail("unexpected_output");
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("result_bundle", bundle, e.bundle);
                    checkOutput("op_count", OpCount, e.cnt);
                end
                expectGo = InValid && InReady;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got stuck expected completion");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        InA      = '0;
        InB      = '0;
        OutReady = 1'b1;
        repeat (3) @(negedge Clock);
        #1;
        checkOutput("reset_go", Go, 1'b0);
        checkOutput("reset_outvalid", OutValid, 1'b0);
        checkOutput("reset_opcount", OpCount, 0);
        checkOutput("reset_addend_a", AddendA, 0);
        checkOutput("reset_bundle", {OutResult, OutZero, OutInf, OutNan, OutTimedOut}, 0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("reset_inready", InReady, 1'b1);
        @(posedge Clock);
        #1;

        // 1.0 + 2.0 = 3.0, fastest adder response
        applyStimulus(32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 1, MODE_NORMAL, 1);
        measureLatency("latency_min", 3);
        waitDrain();
        // -0 + +0 = +0
        applyStimulus(32'h80000000, 32'h00000000, 32'h00000000, 1, 0, 0, 2, MODE_NORMAL, 1);
        waitDrain();
        // max normal + max normal overflows to +inf
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 0, 1, 0, 3, MODE_NORMAL, 1);
        waitDrain();
        // +inf + -inf = NaN
        applyStimulus(32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 0, 1, 1, MODE_NORMAL, 1);
        waitDrain();

        // Adder never answers: watchdog aborts after TIMEOUT WAIT cycles
        applyStimulus(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 0, 0, MODE_NEVER, 1);
        measureLatency("latency_timeout", 10);
        waitDrain();
        // 3.0 + 1.0 = 4.0 after a timeout
        applyStimulus(32'h40400000, 32'h3F800000, 32'h40800000, 0, 0, 0, 2, MODE_NORMAL, 1);
        waitDrain();
        // Ready rises on the last WAIT cycle: capture beats timeout
        applyStimulus(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 0, 8, MODE_NORMAL, 1);
        waitDrain();

        // Three back-to-back pairs with the consumer stalled for 5 cycles
        OutReady = 1'b0;
        fork
            begin
                applyStimulus(32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0, 0, 1, MODE_NORMAL, 1);
                applyStimulus(32'h40000000, 32'h40000000, 32'h40800000, 0, 0, 0, 1, MODE_NORMAL, 1);
                applyStimulus(32'h3F000000, 32'h3F000000, 32'h3F800000, 0, 0, 0, 1, MODE_NORMAL, 1);
            end
            begin
                cycles = 0;
                while (!OutValid && cycles < 100) begin
                    @(negedge Clock);
                    #1;
                    cycles++;
                end
                if (!OutValid) boundFail("backpressure_wait");
                repeat (5) @(negedge Clock);
                OutReady = 1'b1;
            end
        join
        waitDrain();

        // Ready still high from the previous op: only a fresh edge may capture
        applyStimulus(32'h40000000, 32'h40400000, 32'h40A00000, 0, 0, 0, 0, MODE_STUCK, 1);
        waitDrain();

        // Asynchronous reset in the middle of WAIT
        applyStimulus(32'h40000000, 32'h3F800000, 32'h40400000, 0, 0, 0, 0, MODE_NEVER, 0);
        repeat (3) @(negedge Clock);
        #2;
        Reset = 1'b1;
        pushCount = 0;
        #1;
        checkOutput("midwait_go", Go, 1'b0);
        checkOutput("midwait_outvalid", OutValid, 1'b0);
        checkOutput("midwait_opcount", OpCount, 0);
        checkOutput("midwait_addend_a", AddendA, 0);
        checkOutput("midwait_bundle", {OutResult, OutZero, OutInf, OutNan, OutTimedOut}, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        applyStimulus(32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 1, MODE_NORMAL, 1);
        waitDrain();

        checkOutput("final_op_count", OpCount, CNTW'(pushCount));
        checkOutput("go_count", issueQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
